// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request bus used by the fetch unit.
//   req   : fetch unit -> memory, request is active
//   addr  : fetch unit -> memory, word address of the instruction (always the current pc)
//   rdata : memory -> fetch unit, instruction word
//   ready : memory -> fetch unit, request accepted and rdata valid in this same cycle
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ready;

    modport master (output req, output addr, input rdata, input ready);
    modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, computes the next PC from a 4-way
// select, fetches over a req/ready handshake into the instruction register
// and presents the decoded instruction fields.
//
// Ports:
//   CLK, reset        clock (rising edge) and synchronous active-low reset
//   PCWre             PC update enable from the control unit (honoured only in HOLD)
//   PCSrc             next-PC select: 00 pc+4, 01 branch, 10 JR (rs_data), 11 jump
//   IRWre             IR load enable at the cycle the memory returns data
//   rs_data, imm_ext  JR target and branch offset
//   im                instruction memory bus (master side)
//   pc, pc_plus4      current PC and PC+4
//   instr, instr_valid  IR contents and "IR holds the instruction at pc"
//   op, rs, rt, rd, sa, imm16  field slices of instr
//   halted            HALT_OP has been loaded; fetch frozen until reset
//   align_err         sticky flag: a misaligned JR target was seen
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   PCWre,
    input  logic [1:0]             PCSrc,
    input  logic                   IRWre,
    input  logic [31:0]            rs_data,
    input  logic [31:0]            imm_ext,
    instr_fetch_unit_if.master     im,
    output logic [31:0]            pc,
    output logic [31:0]            pc_plus4,
    output logic [31:0]            instr,
    output logic                   instr_valid,
    output logic [5:0]             op,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [4:0]             sa,
    output logic [15:0]            imm16,
    output logic                   halted,
    output logic                   align_err
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic        req_q;
    logic [31:0] next_pc;

    assign pc_plus4 = pc + 32'd4;
    assign im.req   = req_q;
    assign im.addr  = pc;

    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign sa    = instr[10:6];
    assign imm16 = instr[15:0];

    always_comb begin
        // NOTE: default assignment first so no path leaves next_pc unassigned (no latch).
        next_pc = pc_plus4;
        case (PCSrc)
            2'b01:   next_pc = pc_plus4 + (imm_ext << 2);
            2'b10:   next_pc = {rs_data[31:2], 2'b00};
            2'b11:   next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
            default: next_pc = pc_plus4;
        endcase
    end

    // req_q rises one cycle after entering FETCH from reset, so the memory
    // never sees a request in the reset-release cycle.
    always_ff @(posedge CLK) begin
        // NOTE: reset is checked inside the clocked block, so it also overrides
        // PCWre and any im.ready arriving in the same edge.
        if (!reset) begin
            state       <= FETCH;
            req_q       <= 1'b0;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            case (state)
                FETCH: begin
                    if (req_q && im.ready && IRWre) begin
                        instr       <= im.rdata;
                        instr_valid <= 1'b1;
                        req_q       <= 1'b0;
                        state       <= HOLD;
                        if (im.rdata[31:26] == HALT_OP) begin
                            halted <= 1'b1;
                        end
                    end else begin
                        // Data returned with IRWre=0 is dropped; keep requesting.
                        req_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (PCWre && !halted) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        req_q       <= 1'b1;
                        state       <= FETCH;
                        if (PCSrc == 2'b10 && rs_data[1:0] != 2'b00) begin
                            align_err <= 1'b1;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        PCWre = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic        IRWre = 1'b1;
    logic [31:0] rs_data = 32'h0;
    logic [31:0] imm_ext = 32'h0;
    logic [31:0] pc, pc_plus4, instr;
    logic        instr_valid, halted, align_err;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit_if im_bus ();

    instr_fetch_unit dut (
        .CLK         (CLK),
        .reset       (reset),
        .PCWre       (PCWre),
        .PCSrc       (PCSrc),
        .IRWre       (IRWre),
        .rs_data     (rs_data),
        .imm_ext     (imm_ext),
        .im          (im_bus),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr       (instr),
        .instr_valid (instr_valid),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .sa          (sa),
        .imm16       (imm16),
        .halted      (halted),
        .align_err   (align_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One-cycle PCWre pulse with the given select.
    task automatic pulse_pcwre(input logic [1:0] src);
        PCWre = 1'b1;
        PCSrc = src;
        @(negedge CLK);
        PCWre = 1'b0;
    endtask

    // Memory model: wait for a request, stall 'delay' cycles, return 'data'
    // for one cycle with IRWre set to 'irwre'.
    task automatic serve(input logic [31:0] data, input int delay, input logic irwre);
        int n = 0;
        while (im_bus.req !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("req_wait", {31'h0, im_bus.req}, 32'h1);
        repeat (delay) @(negedge CLK);
        im_bus.ready = 1'b1;
        im_bus.rdata = data;
        IRWre        = irwre;
        @(negedge CLK);
        im_bus.ready = 1'b0;
        IRWre        = 1'b1;
    endtask

    initial begin
        im_bus.ready = 1'b0;
        im_bus.rdata = 32'h0;

        // Reset and first fetch.
        repeat (2) @(negedge CLK);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_align", {31'h0, align_err}, 32'h0);
        check("rst_req", {31'h0, im_bus.req}, 32'h0);
        reset = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check("wait_req", {31'h0, im_bus.req}, 32'h1);
            check("wait_addr", im_bus.addr, 32'h0);
            @(negedge CLK);
        end
        im_bus.ready = 1'b1;
        im_bus.rdata = 32'h0822_0005;
        @(negedge CLK);
        im_bus.ready = 1'b0;
        check("f1_valid", {31'h0, instr_valid}, 32'h1);
        check("f1_op", {26'h0, op}, 32'h2);
        check("f1_rs", {27'h0, rs}, 32'h1);
        check("f1_rt", {27'h0, rt}, 32'h2);
        check("f1_imm16", {16'h0, imm16}, 32'h5);
        check("f1_req_low", {31'h0, im_bus.req}, 32'h0);

        // Walk sequentially to pc=0x10.
        for (int i = 0; i < 4; i++) begin
            pulse_pcwre(2'b00);
            serve(32'h0, 0, 1'b1);
        end
        check("seq_pc10", pc, 32'h10);
        check("seq_pc_plus4", pc_plus4, 32'h14);

        // Sequential then negative branch.
        pulse_pcwre(2'b00);
        check("seq_pc14", pc, 32'h14);
        check("seq_valid_clr", {31'h0, instr_valid}, 32'h0);
        serve(32'h0, 0, 1'b1);
        imm_ext = 32'hFFFF_FFFE;
        pulse_pcwre(2'b01);
        check("br_back", pc, 32'h10);
        serve(32'h0, 0, 1'b1);

        // Forward branch to 0x1000: 0x14 + (0x3FB << 2) = 0x1000.
        imm_ext = 32'h0000_03FB;
        pulse_pcwre(2'b01);
        check("br_fwd", pc, 32'h1000);
        serve(32'hE000_0040, 0, 1'b1);
        pulse_pcwre(2'b11);
        check("jump_pc", pc, 32'h100);
        check("align_before_jr", {31'h0, align_err}, 32'h0);
        serve(32'h0, 0, 1'b1);
        rs_data = 32'h0000_0203;
        pulse_pcwre(2'b10);
        check("jr_pc", pc, 32'h200);
        check("jr_align", {31'h0, align_err}, 32'h1);

        // PCWre during the fetch wait is ignored.
        pulse_pcwre(2'b00);
        check("pcwre_in_fetch", pc, 32'h200);
        // Data returned with IRWre=0 is dropped and the request reissued.
        serve(32'h1234_5678, 0, 1'b0);
        check("drop_instr", instr, 32'h0);
        check("drop_valid", {31'h0, instr_valid}, 32'h0);
        check("drop_reissue", {31'h0, im_bus.req}, 32'h1);
        serve(32'h0000_1111, 1, 1'b1);
        check("reissue_instr", instr, 32'h0000_1111);

        // Wrap-around from 0xFFFF_FFFC.
        rs_data = 32'hFFFF_FFFC;
        pulse_pcwre(2'b10);
        check("jr_top", pc, 32'hFFFF_FFFC);
        check("top_plus4", pc_plus4, 32'h0);
        serve(32'h0123_4567, 0, 1'b1);
        pulse_pcwre(2'b00);
        check("wrap_pc", pc, 32'h0);
        check("wrap_addr", im_bus.addr, 32'h0);
        check("align_sticky", {31'h0, align_err}, 32'h1);
        serve(32'h0123_4567, 0, 1'b1);
        pulse_pcwre(2'b00);
        check("pre_rst_pc", pc, 32'h4);

        // Reset mid-fetch with im_ready asserted in the same edge.
        reset        = 1'b0;
        im_bus.ready = 1'b1;
        im_bus.rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        im_bus.ready = 1'b0;
        check("midrst_instr", instr, 32'h0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_valid", {31'h0, instr_valid}, 32'h0);
        check("midrst_align", {31'h0, align_err}, 32'h0);
        reset = 1'b1;
        @(negedge CLK);

        // HALT freezes fetch.
        serve(32'hFC00_0000, 0, 1'b1);
        check("halt_flag", {31'h0, halted}, 32'h1);
        check("halt_op", {26'h0, op}, 32'h3F);
        pulse_pcwre(2'b00);
        check("halt_pc", pc, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("halt_req", {31'h0, im_bus.req}, 32'h0);
            @(negedge CLK);
        end
        check("halt_instr", instr, 32'hFC00_0000);
        check("halt_pc_end", pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the multicycle control unit.
- Holds the PC and computes next-PC from the 4-way PCSrc select.
- Fetches the instruction from instruction memory over a req/ready handshake and latches it into the instruction register (IR).
- Presents decoded fields (op, rs, rt, rd, sa, imm16) to the control unit and register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OP, 6'b111111, opcode that freezes fetch

Ports:
CLK  input  1  clock, rising-edge active
reset  input  1  synchronous, active-low reset
PCWre  input  1  PC update enable from control unit; sampled at rising edge
PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 JR (rs_data), 11 jump
IRWre  input  1  IR load enable; data is discarded when IRWre=0 at return
rs_data  input  32  register-file rs value, used as JR target
imm_ext  input  32  extended immediate from extender, used as branch offset
im_req  output  1  instruction memory request
im_addr  output  32  instruction memory word address (= pc)
im_rdata  input  32  instruction memory read data
im_ready  input  1  memory accepts request and returns im_rdata in the same cycle
pc  output  32  current PC
pc_plus4  output  32  pc + 4 (to JAL write-back mux)
instr  output  32  IR contents
instr_valid  output  1  IR holds the instruction at pc
op, rs, rt, rd, sa  output  6/5/5/5/5  instr[31:26], [25:21], [20:16], [15:11], [10:6]
imm16  output  16  instr[15:0]
halted  output  1  HALT_OP has been fetched
align_err  output  1  sticky: misaligned JR target was seen

Behaviour:
- Reset (reset=0 at rising edge):
  - pc=RESET_PC, instr=0, instr_valid=0, halted=0, align_err=0, im_req=0.
  - FSM goes to FETCH.
  - Reset mid-fetch aborts the transaction; any im_ready in that cycle is ignored.
- FSM states: FETCH, HOLD.
  - FETCH: im_req=1, im_addr=pc.
    - On im_ready=1: if IRWre=1, instr<=im_rdata and instr_valid<=1; go to HOLD.
    - If IRWre=0 at im_ready, data is dropped and the FSM stays in FETCH; the request is reissued next cycle.
    - Latency: IR is valid one cycle after the first cycle in which im_ready=1.
  - HOLD: im_req=0; IR stable.
    - On PCWre=1 and halted=0: pc<=next_pc, instr_valid<=0, go to FETCH.
- next_pc, all arithmetic modulo 2^32 with wrap-around:
  - 00: pc+4
  - 01: pc+4 + (imm_ext<<2)
  - 10: {rs_data[31:2],2'b00}
  - 11: {pc_plus4[31:28], instr[25:0], 2'b00}
- Uses the IR and pc values held before the update edge.
- JR with rs_data[1:0]!=0: target is aligned as above and align_err is set (sticky until reset).
- PCWre while in FETCH is ignored; pc is unchanged.
- halted:
  - Set in the same edge that loads an IR value whose [31:26]==HALT_OP.
  - While halted=1, PCWre is ignored; im_req stays 0 and the IR is held.
  - Cleared only by reset.
- PCWre and reset in the same edge: reset wins.
- pc at 32'hFFFF_FFFC with PCSrc=00 wraps to 32'h0000_0000.
- Decoded field outputs are pure slices of instr; no added latency.

Test Plan:
- Reset and first fetch:
  - Stimulus: reset low 2 cycles, then high; memory returns 32'h0822_0005 with im_ready delayed 3 cycles.
  - Required: im_req=1 with im_addr=0 until ready; the next cycle gives instr_valid=1, op=6'b000010, rs=1, rt=2, imm16=5.
- Sequential and branch:
  - Stimulus: in HOLD at pc=0x10, pulse PCWre with PCSrc=00.
  - Required: pc=0x14.
  - Stimulus: then PCSrc=01 with imm_ext=32'hFFFF_FFFE.
  - Required: pc=0x14+4-8=0x10.
- Jump and JR:
  - Stimulus: IR=32'hE000_0040, pc=0x1000, PCSrc=11.
  - Required: pc=0x100.
  - Stimulus: PCSrc=10, rs_data=0x203.
  - Required: pc=0x200, align_err=1.
- HALT:
  - Stimulus: fetch 32'hFC00_0000, then pulse PCWre with PCSrc=00.
  - Required: halted=1; pc unchanged; im_req stays 0 for 10 cycles.
- Ignored and dropped events:
  - Stimulus: PCWre=1 during FETCH wait.
  - Required: pc unchanged.
  - Stimulus: IRWre=0 at im_ready.
  - Required: instr unchanged, request reissued.
  - Stimulus: reset asserted mid-fetch with im_ready=1.
  - Required: instr=0, pc=RESET_PC.
- Wrap-around:
  - Stimulus: pc=32'hFFFF_FFFC, PCSrc=00, PCWre=1.
  - Required: pc=0, im_addr=0.
